event_timer_bank: RTL and testbench



---
 rtl/event_timer_bank.sv | 143 ++++++++++++++
 tb/tb_event_timer_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_timer_bank.sv
// event_timer_bank: a bank of independent microsecond countdown timers.
// Each timer raises a one-cycle pulse on its bit of `expired` when its count
// runs out. A shared prescaler divides sysclk down to the microsecond tick.
//
// Optional feature: define EVENT_TIMER_PERIODIC_EN to add a reload register
// per timer. With the reload register, a timer restarts on expiry for periodic
// events. When the macro is undefined, every timer is one-shot and
// reload_load is ignored.
//
// Ports:
//   sysclk, sysreset  clock and asynchronous active-high reset
//   data_in[15:0]     MCU write data
//   select_load       latch data_in[3:0] as the selected timer index
//   count_load        load data_in into the selected timer's count (0 cancels)
//   reload_load       write data_in to the selected timer's reload register
//   count_out[15:0]   registered remaining count of the selected timer
//   expired[]         one-cycle expiry pulses, bit i = timer i
module event_timer_bank #(
  parameter int unsigned NUM_TIMERS   = 8,
  parameter int unsigned PRESCALE_DIV = 50,
  parameter int unsigned TOP_TIMER    = NUM_TIMERS - 1
) (
  input  logic               sysclk,
  input  logic               sysreset,
  input  logic [15:0]        data_in,
  input  logic               select_load,
  input  logic               count_load,
  input  logic               reload_load,
  output logic [15:0]        count_out,
  output logic [TOP_TIMER:0] expired
);

  localparam int unsigned PW = 10;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 4;

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [CW-1:0]         count_q [NUM_TIMERS];
  logic [CW-1:0]         count_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] armed_q, armed_d;
  logic [TOP_TIMER:0]    expired_q, expired_d;
  logic [CW-1:0]         count_out_q, count_out_d;
  logic                  tick;
  logic [NUM_TIMERS-1:0] sel_hit;
  logic                  wr_count;
  logic                  wr_reload;

`ifdef EVENT_TIMER_PERIODIC_EN
  logic [CW-1:0]         reload_q [NUM_TIMERS];
  logic [CW-1:0]         reload_d [NUM_TIMERS];
`else
  logic                  unused_reload_load;
  assign unused_reload_load = reload_load;
`endif

  assign tick      = (presc_q == PW'(PRESCALE_DIV - 1));
  // select_load takes precedence over the data writes when strobes overlap
  assign wr_count  = count_load  && !select_load;
  assign wr_reload = reload_load && !select_load;

  // One-hot decode of the selected timer; an out-of-range index hits nothing
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < int'(NUM_TIMERS); i++) begin
      sel_hit[i] = (sel_q == SW'(i));
    end
  end

  // Next-state logic for prescaler, selection, timers and outputs
  always_comb begin
    presc_d     = tick ? '0 : presc_q + PW'(1);
    sel_d       = select_load ? data_in[SW-1:0] : sel_q;
    count_d     = count_q;
    armed_d     = armed_q;
    expired_d   = '0;
    count_out_d = '0;
`ifdef EVENT_TIMER_PERIODIC_EN
    reload_d    = reload_q;
`endif
    for (int i = 0; i < int'(NUM_TIMERS); i++) begin
      if (sel_hit[i]) begin
        count_out_d = count_q[i];
      end
      // A write wins over a coincident tick: no decrement, no expiry
      if (wr_count && sel_hit[i]) begin
        count_d[i] = data_in;
        armed_d[i] = |data_in;
      end else if (tick && armed_q[i]) begin
        if (count_q[i] > CW'(1)) begin
          count_d[i] = count_q[i] - CW'(1);
        end else begin
          expired_d[i] = 1'b1;
`ifdef EVENT_TIMER_PERIODIC_EN
          if (reload_q[i] != '0) begin
            count_d[i] = reload_q[i];
          end else begin
            count_d[i] = '0;
            armed_d[i] = 1'b0;
          end
`else
          count_d[i] = '0;
          armed_d[i] = 1'b0;
`endif
        end
      end
`ifdef EVENT_TIMER_PERIODIC_EN
      if (wr_reload && sel_hit[i]) begin
        reload_d[i] = data_in;
      end
`endif
    end
  end

  // State registers
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      presc_q     <= '0;
      sel_q       <= '0;
      count_q     <= '{default: '0};
      armed_q     <= '0;
      expired_q   <= '0;
      count_out_q <= '0;
`ifdef EVENT_TIMER_PERIODIC_EN
      reload_q    <= '{default: '0};
`endif
    end else begin
      presc_q     <= presc_d;
      sel_q       <= sel_d;
      count_q     <= count_d;
      armed_q     <= armed_d;
      expired_q   <= expired_d;
      count_out_q <= count_out_d;
`ifdef EVENT_TIMER_PERIODIC_EN
      reload_q    <= reload_d;
`endif
    end
  end

  assign count_out = count_out_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_event_timer_bank.sv
// Testbench for event_timer_bank (NUM_TIMERS=8, PRESCALE_DIV=4).
// Stimulus pushes the edge on which each expiry pulse must appear. A separate
// monitor pops and compares whenever a pulse is due or the DUT pulses.
module tb_event_timer_bank;

  localparam int NT  = 8;
  localparam int DIV = 4;

  logic          sysclk;
  logic          sysreset;
  logic [15:0]   data_in;
  logic          select_load;
  logic          count_load;
  logic          reload_load;
  logic [15:0]   count_out;
  logic [NT-1:0] expired;

  event_timer_bank #(
    .NUM_TIMERS  (NT),
    .PRESCALE_DIV(DIV)
  ) dut (
    .sysclk      (sysclk),
    .sysreset    (sysreset),
    .data_in     (data_in),
    .select_load (select_load),
    .count_load  (count_load),
    .reload_load (reload_load),
    .count_out   (count_out),
    .expired     (expired)
  );

  typedef struct {
    int            edge_no;
    logic [NT-1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   errors = 0;
  int   checks = 0;
  int   ecnt;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Clock edges since reset release; the prescaler phase equals ecnt mod DIV
  always @(posedge sysclk or posedge sysreset) begin
    if (sysreset) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Monitor: compare expiry pulses against the scoreboard
  always @(negedge sysclk) begin
    if (!sysreset) begin
      while (exp_q.size() != 0 && exp_q[0].edge_no < ecnt) begin
        mon_x = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: edge %0d mask %b never seen", mon_x.edge_no, mon_x.mask);
      end
      if (exp_q.size() != 0 && exp_q[0].edge_no == ecnt) begin
        mon_x = exp_q.pop_front();
        checks++;
        if (expired !== mon_x.mask) begin
          errors++;
          $display("FAIL pulse_edge%0d: expired=%b expected %b", ecnt, expired, mon_x.mask);
        end
      end else if (expired !== '0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: edge %0d expired=%b expected 0", ecnt, expired);
      end
    end
  end

  task automatic push_edge(input int t, input int e);
    exp_t x;
    int   k;
    k = 0;
    while (k < exp_q.size() && exp_q[k].edge_no < e) k++;
    if (k < exp_q.size() && exp_q[k].edge_no == e) begin
      x = exp_q[k];
      x.mask[t] = 1'b1;
      exp_q[k] = x;
    end else begin
      x.edge_no = e;
      x.mask    = '0;
      x.mask[t] = 1'b1;
      exp_q.insert(k, x);
    end
  endtask

  // First tick edge strictly after the load edge (a coincident tick is lost)
  function automatic int first_tick(input int l);
    return (l / DIV + 1) * DIV;
  endfunction

  // Load of n at edge l expires on the n-th tick edge after l
  function automatic int expiry_edge(input int l, input int n);
    return first_tick(l) + DIV * (n - 1);
  endfunction

  // One write cycle; on return ecnt equals the edge that applied it
  task automatic wr(input logic s, input logic c, input logic r, input logic [15:0] d);
    select_load = s;
    count_load  = c;
    reload_load = r;
    data_in     = d;
    @(negedge sysclk);
    select_load = 1'b0;
    count_load  = 1'b0;
    reload_load = 1'b0;
    data_in     = '0;
  endtask

  task automatic wait_until(input int e);
    while (ecnt < e) @(negedge sysclk);
  endtask

  task automatic chk_count(input string name, input logic [15:0] exp);
    checks++;
    if (count_out !== exp) begin
      errors++;
      $display("FAIL %s: count_out=%0d expected %0d", name, count_out, exp);
    end
  endtask

  task automatic chk_exp_zero(input string name);
    checks++;
    if (expired !== '0) begin
      errors++;
      $display("FAIL %s: expired=%b expected 0", name, expired);
    end
  endtask

  int l, l2, t1, e0;

  initial begin
    sysreset    = 1'b1;
    data_in     = '0;
    select_load = 1'b0;
    count_load  = 1'b0;
    reload_load = 1'b0;
    repeat (3) @(negedge sysclk);
    chk_count("reset_count_out", 16'd0);
    chk_exp_zero("reset_expired");
    sysreset = 1'b0;
    @(negedge sysclk);

    // Reset mid-count: timer 2 loaded with 5, reset after 3 ticks
    wr(1, 0, 0, 16'd2);
    wr(0, 1, 0, 16'd5);
    l = ecnt;
    wait_until(first_tick(l) + 2 * DIV);
    sysreset = 1'b1;
    exp_q.delete();
    @(negedge sysclk);
    chk_count("midreset_count_out", 16'd0);
    chk_exp_zero("midreset_expired");
    @(negedge sysclk);
    sysreset = 1'b0;
    repeat (40) @(negedge sysclk);
    wr(1, 0, 0, 16'd2);
    @(negedge sysclk);
    chk_count("after_reset_t2", 16'd0);

    // Overlapping strobes: only the select is applied
    wr(1, 1, 0, 16'd3);
    @(negedge sysclk);
    chk_count("multi_strobe_t3", 16'd0);

    // One-shot on timer 3 with count 3
    wr(0, 1, 0, 16'd3);
    l = ecnt;
    push_edge(3, expiry_edge(l, 3));
    @(negedge sysclk);
    chk_count("oneshot_c3", 16'd3);
    t1 = first_tick(l);
    wait_until(t1 + 1);
    chk_count("oneshot_c2", 16'd2);
    wait_until(t1 + 1 + DIV);
    chk_count("oneshot_c1", 16'd1);
    wait_until(t1 + 1 + 2 * DIV);
    chk_count("oneshot_c0", 16'd0);
    wait_until(t1 + 4 * DIV);

    // Cancel: timer 0 loaded with 5, cancelled after 2 ticks
    wr(1, 0, 0, 16'd0);
    wr(0, 1, 0, 16'd5);
    l = ecnt;
    wait_until(first_tick(l) + DIV);
    wr(0, 1, 0, 16'd0);
    @(negedge sysclk);
    chk_count("cancel_c0", 16'd0);
    repeat (30) @(negedge sysclk);

    // Restart: load 4, load 4 again after 2 ticks
    wr(0, 1, 0, 16'd4);
    l = ecnt;
    wait_until(first_tick(l) + DIV);
    wr(0, 1, 0, 16'd4);
    l2 = ecnt;
    push_edge(0, expiry_edge(l2, 4));
    @(negedge sysclk);
    chk_count("restart_c4", 16'd4);
    wait_until(expiry_edge(l2, 4) + 3);

    // Collision: timers 1 and 6 loaded with 2 inside one tick window
    wr(1, 0, 0, 16'd1);
    while (ecnt % DIV != 0) @(negedge sysclk);
    wr(0, 1, 0, 16'd2);
    push_edge(1, expiry_edge(ecnt, 2));
    wr(1, 0, 0, 16'd6);
    wr(0, 1, 0, 16'd2);
    push_edge(6, expiry_edge(ecnt, 2));
    wait_until(expiry_edge(ecnt, 2) + 4);

    // Load coincident with the expiry tick: no pulse, new count wins
    wr(1, 0, 0, 16'd5);
    wr(0, 1, 0, 16'd1);
    while (ecnt % DIV != DIV - 1) @(negedge sysclk);
    wr(0, 1, 0, 16'd3);
    l = ecnt;
    push_edge(5, expiry_edge(l, 3));
    @(negedge sysclk);
    chk_count("coincident_c3", 16'd3);
    wait_until(expiry_edge(l, 3) + 4);

    // Out-of-range select: writes are no-ops, count_out reads 0
    wr(1, 0, 0, 16'd9);
    wr(0, 1, 0, 16'd7);
    @(negedge sysclk);
    chk_count("oor_count_out", 16'd0);
    repeat (40) @(negedge sysclk);
    wr(1, 0, 0, 16'd1);
    @(negedge sysclk);
    chk_count("oor_t1_untouched", 16'd0);

    // Timer 4: reload 2, load 2
    wr(1, 0, 0, 16'd4);
    wr(0, 0, 1, 16'd2);
    wr(0, 1, 0, 16'd2);
    l  = ecnt;
    e0 = expiry_edge(l, 2);
`ifdef EVENT_TIMER_PERIODIC_EN
    for (int p = 0; p < 6; p++) push_edge(4, e0 + p * 2 * DIV);
    wait_until(e0 + 10 * DIV + 1);
    wr(0, 1, 0, 16'd0);
    repeat (30) @(negedge sysclk);
    chk_count("periodic_cancel_c0", 16'd0);
    // Cancel kept the reload value: load 1 gives two periodic pulses
    wr(0, 1, 0, 16'd1);
    l  = ecnt;
    e0 = expiry_edge(l, 1);
    push_edge(4, e0);
    push_edge(4, e0 + 2 * DIV);
    wait_until(e0 + 2 * DIV + 1);
    wr(0, 1, 0, 16'd0);
    repeat (20) @(negedge sysclk);
`else
    push_edge(4, e0);
    wait_until(e0 + 1);
    chk_count("oneshot_t4_c0", 16'd0);
    repeat (30) @(negedge sysclk);
`endif

    repeat (5) @(negedge sysclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
